// File: rtl/ctrl_frame_parser.sv
// ctrl_frame_parser: assembles SYNC/x/y/btn/chk frames from the SPI byte stream into controller state; CTRL_EDGE_EN adds buttons_pressed_out.
// Latency: controller_out and frame_valid_out update one cycle after the checksum byte strobe.
// Backpressure: none; every byte_valid_in strobe is consumed, back-to-back strobes included.
module ctrl_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 2000,
    parameter int         STALE_CYCLES   = 1_000_000,
    parameter logic [7:0] NEUTRAL_XY     = 8'h80
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic [23:0] controller_out,
    output logic        frame_valid_out,
    output logic        link_up_out,
    output logic [7:0]  err_count_out
`ifdef CTRL_EDGE_EN
    ,
    output logic [7:0]  buttons_pressed_out
`endif
);

    typedef struct packed {
        logic [7:0] joystick_x;
        logic [7:0] joystick_y;
        logic [7:0] buttons;
    } controller_t;

    typedef enum logic [2:0] {SYNC, GET_X, GET_Y, GET_BTN, GET_CHK} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam controller_t NEUTRAL = controller_t'({NEUTRAL_XY, NEUTRAL_XY, 8'h00});

    state_t      state, state_nxt;
    controller_t shadow;
    controller_t ctrl_q;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] stale_cnt;
    logic [7:0]  chk_sum;
    logic        timeout_fire;
    logic        frame_good;
    logic        chk_bad;
    logic        stale_expire;

    always_comb begin
        state_nxt    = state;
        chk_sum      = shadow.joystick_x + shadow.joystick_y + shadow.buttons;
        timeout_fire = (state != SYNC) && !byte_valid_in && (tmo_cnt == TW'(TIMEOUT_CYCLES));
        frame_good   = (state == GET_CHK) && byte_valid_in && (byte_in == chk_sum);
        chk_bad      = (state == GET_CHK) && byte_valid_in && (byte_in != chk_sum);
        stale_expire = !frame_good && (stale_cnt == SW'(STALE_CYCLES - 1));
        if (timeout_fire) begin
            state_nxt = SYNC;
        end else if (byte_valid_in) begin
            case (state)
                SYNC:    state_nxt = (byte_in == SYNC_BYTE) ? GET_X : SYNC;
                GET_X:   state_nxt = GET_Y;
                GET_Y:   state_nxt = GET_BTN;
                GET_BTN: state_nxt = GET_CHK;
                GET_CHK: state_nxt = SYNC;
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // tmo_cnt holds the cycles elapsed since the last strobe, the current cycle included.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shadow          <= '0;
            ctrl_q          <= NEUTRAL;
            frame_valid_out <= 1'b0;
            link_up_out     <= 1'b0;
            err_count_out   <= 8'h00;
            tmo_cnt         <= '0;
            stale_cnt       <= '0;
        end else begin
            frame_valid_out <= frame_good;

            if (byte_valid_in) begin
                case (state)
                    GET_X:   shadow.joystick_x <= byte_in;
                    GET_Y:   shadow.joystick_y <= byte_in;
                    GET_BTN: shadow.buttons    <= byte_in;
                    default: ;
                endcase
            end

            if (byte_valid_in) begin
                tmo_cnt <= TW'(1);
            end else if (state == SYNC || timeout_fire) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if ((chk_bad || timeout_fire) && err_count_out != 8'hFF) begin
                err_count_out <= err_count_out + 8'd1;
            end

            if (frame_good) begin
                ctrl_q      <= shadow;
                link_up_out <= 1'b1;
                stale_cnt   <= '0;
            end else if (stale_cnt != SW'(STALE_CYCLES)) begin
                stale_cnt <= stale_cnt + SW'(1);
                if (stale_expire) begin
                    link_up_out <= 1'b0;
                    ctrl_q      <= NEUTRAL;
                end
            end
        end
    end

    assign controller_out = ctrl_q;

`ifdef CTRL_EDGE_EN
    logic [7:0] prev_buttons;

    // prev_buttons is wiped on link loss so the first frame after link-up reports every held button.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_buttons        <= 8'h00;
            buttons_pressed_out <= 8'h00;
        end else begin
            buttons_pressed_out <= frame_good ? (shadow.buttons & ~prev_buttons) : 8'h00;
            if (frame_good) begin
                prev_buttons <= shadow.buttons;
            end else if (stale_expire) begin
                prev_buttons <= 8'h00;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_frame_parser.sv
// Bench for ctrl_frame_parser: directed literal checks plus a randomized byte stream scored every cycle
// against a queue-based frame model; timeout expiry cycle = TMO cycles after the previous strobe.
module tb_ctrl_frame_parser;

    localparam int TMO   = 20;
    localparam int STALE = 50;
    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [23:0] NEUTRAL = 24'h808000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [23:0] controller;
    logic        frame_valid;
    logic        link_up;
    logic [7:0]  err_count;
`ifdef CTRL_EDGE_EN
    logic [7:0]  buttons_pressed;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ctrl_frame_parser #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TMO),
        .STALE_CYCLES(STALE),
        .NEUTRAL_XY(8'h80)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .byte_in(byte_in),
        .byte_valid_in(byte_valid),
        .controller_out(controller),
        .frame_valid_out(frame_valid),
        .link_up_out(link_up),
        .err_count_out(err_count)
`ifdef CTRL_EDGE_EN
        ,
        .buttons_pressed_out(buttons_pressed)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: payload bytes of the frame in progress, idle time since last strobe, time since last good frame.
    logic [7:0]  pay_q[$];
    bit          in_frame;
    int          since_byte, since_good, m_sumi, m_err;
    bit          m_good;
    logic [7:0]  m_sum, m_bp, m_prev;
    logic [23:0] m_ctrl;
    logic        m_fv, m_link;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_q.delete();
            in_frame = 0; since_byte = 0; since_good = 0; m_err = 0;
            m_ctrl = NEUTRAL; m_fv = 0; m_link = 0; m_bp = 0; m_prev = 0;
        end else begin
            m_good = 0; m_fv = 0; m_bp = 0;
            if (byte_valid) begin
                since_byte = 0;
                if (!in_frame) begin
                    in_frame = (byte_in == SYNC);
                end else if (pay_q.size() < 3) begin
                    pay_q.push_back(byte_in);
                end else begin
                    m_sumi = int'(pay_q[0]) + int'(pay_q[1]) + int'(pay_q[2]);
                    m_sum  = 8'(m_sumi % 256);
                    if (byte_in == m_sum) m_good = 1;
                    else if (m_err < 255) m_err++;
                    in_frame = 0;
                end
            end else if (in_frame) begin
                since_byte++;
                if (since_byte == TMO) begin
                    if (m_err < 255) m_err++;
                    in_frame = 0;
                end
            end
            if (m_good) begin
                m_ctrl = {pay_q[0], pay_q[1], pay_q[2]};
                m_fv = 1; m_link = 1; since_good = 0;
                m_bp = pay_q[2] & ~m_prev;
                m_prev = pay_q[2];
            end else begin
                since_good++;
                if (since_good >= STALE) begin
                    m_link = 0; m_ctrl = NEUTRAL; m_prev = 0;
                end
            end
            if (!in_frame) pay_q.delete();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_controller", {8'h00, controller}, {8'h00, m_ctrl});
            check("cyc_frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
            check("cyc_link_up", {31'd0, link_up}, {31'd0, m_link});
            check("cyc_err_count", {24'd0, err_count}, m_err);
`ifdef CTRL_EDGE_EN
            check("cyc_buttons_pressed", {24'd0, buttons_pressed}, {24'd0, m_bp});
`endif
        end
    end

    task automatic do_reset();
        rst_n = 0; byte_valid = 0; byte_in = 8'h00;
        @(posedge clk); #1;
        check("rst_controller", {8'h00, controller}, {8'h00, NEUTRAL});
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_link_up", {31'd0, link_up}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b; byte_valid = 1;
        @(posedge clk); #1;
        byte_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b, input logic [7:0] c);
        send(SYNC); send(x); send(y); send(b); send(c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] x, y, b;
        int k, gap;

        do_reset();

        // Good frame, back-to-back bytes.
        send_frame(8'h10, 8'h20, 8'h03, 8'h33);
        check("good_ctrl", {8'h00, controller}, 32'h00102003);
        check("good_fv", {31'd0, frame_valid}, 32'd1);
        check("good_link", {31'd0, link_up}, 32'd1);
        check("good_err", {24'd0, err_count}, 32'd0);
        check("model_pin_good", {8'h00, m_ctrl}, 32'h00102003);
        idle(1);
        check("good_fv_single", {31'd0, frame_valid}, 32'd0);

        // Bad checksum, then a good frame.
        do_reset();
        send_frame(8'h10, 8'h20, 8'h03, 8'h34);
        check("bad_ctrl", {8'h00, controller}, 32'h00808000);
        check("bad_fv", {31'd0, frame_valid}, 32'd0);
        check("bad_err", {24'd0, err_count}, 32'd1);
        check("model_pin_bad_err", m_err, 32'd1);
        send_frame(8'h01, 8'h02, 8'h04, 8'h07);
        check("after_bad_ctrl", {8'h00, controller}, 32'h00010204);

        // Junk before sync, payload bytes equal to SYNC.
        do_reset();
        send(8'h00); send(8'hFF);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hEF);
        check("sync_payload_ctrl", {8'h00, controller}, 32'h00A5A5A5);
        check("sync_payload_err", {24'd0, err_count}, 32'd0);

        // Inter-byte timeout fires in the TMO-th cycle after the last strobe.
        do_reset();
        send(SYNC); send(8'h10);
        idle(TMO - 1);
        check("tmo_before", {24'd0, err_count}, 32'd0);
        idle(1);
        check("tmo_fired", {24'd0, err_count}, 32'd1);
        send_frame(8'h01, 8'h02, 8'h04, 8'h07);
        check("tmo_resync_ctrl", {8'h00, controller}, 32'h00010204);

        // Byte in the expiry cycle is accepted.
        do_reset();
        send(SYNC); send(8'h10);
        idle(TMO - 1);
        send(8'h20); send(8'h03); send(8'h33);
        check("tmo_edge_fv", {31'd0, frame_valid}, 32'd1);
        check("tmo_edge_ctrl", {8'h00, controller}, 32'h00102003);
        check("tmo_edge_err", {24'd0, err_count}, 32'd0);

        // Stale watchdog.
        do_reset();
        send_frame(8'h10, 8'h20, 8'h03, 8'h33);
        idle(STALE - 1);
        check("stale_before_link", {31'd0, link_up}, 32'd1);
        check("stale_before_ctrl", {8'h00, controller}, 32'h00102003);
        idle(1);
        check("stale_link", {31'd0, link_up}, 32'd0);
        check("stale_ctrl", {8'h00, controller}, 32'h00808000);
        send_frame(8'h11, 8'h22, 8'h00, 8'h33);
        check("stale_restore_link", {31'd0, link_up}, 32'd1);

        // Asynchronous reset mid-frame.
        do_reset();
        send_frame(8'h10, 8'h20, 8'h03, 8'h34);
        send_frame(8'h10, 8'h20, 8'h03, 8'h33);
        send(SYNC); send(8'h10); send(8'h20);
        #2 rst_n = 0;
        #1;
        check("arst_ctrl", {8'h00, controller}, 32'h00808000);
        check("arst_link", {31'd0, link_up}, 32'd0);
        check("arst_err", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        send(8'h03); send(8'h33);
        check("arst_partial_dropped", {8'h00, controller}, 32'h00808000);
        check("arst_partial_err", {24'd0, err_count}, 32'd0);

        // Error counter saturation.
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'h01);
            if (i == 254) check("sat_254", {24'd0, err_count}, 32'h000000FE);
        end
        check("sat_ff", {24'd0, err_count}, 32'h000000FF);

`ifdef CTRL_EDGE_EN
        do_reset();
        send_frame(8'h00, 8'h00, 8'h01, 8'h01);
        check("edge_first", {24'd0, buttons_pressed}, 32'h01);
        send_frame(8'h00, 8'h00, 8'h03, 8'h03);
        check("edge_second", {24'd0, buttons_pressed}, 32'h02);
        idle(1);
        check("edge_idle", {24'd0, buttons_pressed}, 32'h00);
`endif

        // Randomized stream scored by the per-cycle model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                x = 8'($urandom); y = 8'($urandom); b = 8'($urandom);
                send(SYNC);
                for (int j = 0; j < 4; j++) begin
                    gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO + 3) : 0;
                    if (gap > 0) idle(gap);
                    case (j)
                        0: send(x);
                        1: send(y);
                        2: send(b);
                        default: send((k == 5) ? 8'(x + y + b + 8'd1) : 8'(x + y + b));
                    endcase
                end
            end else if (k == 6) begin
                send(8'($urandom));
            end else if (k == 7) begin
                send(SYNC);
                repeat ($urandom_range(1, 3)) send(8'($urandom));
            end else begin
                idle($urandom_range(0, 60));
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_frame_parser.md
Name: ctrl_frame_parser

Overview:
- Sits between the SPI controller link's received-byte stream and the system I/O bus.
- Assembles framed controller packets, checks them, and holds the last good controller_t state for consumers.
- Drives neutral state when the link goes quiet.
- Frame format on the wire, in order: SYNC_BYTE, joystick_x, joystick_y, buttons, checksum. Checksum = (x + y + buttons) mod 256.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 2000, max clk cycles allowed between bytes inside a frame.
- STALE_CYCLES, 1_000_000, cycles without a good frame before link is declared down.
- NEUTRAL_XY, 8'h80, joystick value driven when link is down or in reset.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- byte_in  input  8  received SPI byte
- byte_valid_in  input  1  one-cycle strobe, byte_in valid
- controller_out  output  24  controller_t {joystick_x, joystick_y, buttons}; feeds sys_io_bus controller
- frame_valid_out  output  1  one-cycle pulse when controller_out is updated from a good frame
- link_up_out  output  1  high while good frames arrive within STALE_CYCLES
- err_count_out  output  8  saturating count of checksum failures plus inter-byte timeouts

Behaviour:
- Reset (rst_in low, async):
  - state=SYNC; controller_out={NEUTRAL_XY, NEUTRAL_XY, 8'h00}.
  - frame_valid_out=0, link_up_out=0, err_count_out=0.
  - All counters cleared.
  - Reset asserted mid-frame discards the partial frame.
- FSM states: SYNC, GET_X, GET_Y, GET_BTN, GET_CHK. Transitions happen only on byte_valid_in, except on timeout.
  - SYNC: byte==SYNC_BYTE -> GET_X; any other byte is dropped silently (no error count).
  - GET_X, GET_Y, GET_BTN: latch the byte into a shadow register, advance one state.
  - GET_CHK:
    - byte == (x+y+btn) mod 256: copy shadow to controller_out on the next clock edge and pulse frame_valid_out that same cycle (latency 1 cycle after the checksum byte strobe). Then -> SYNC.
    - Mismatch: increment err_count_out, leave controller_out unchanged, -> SYNC.
- Checksum arithmetic: 8-bit wrap, no carry kept. SYNC_BYTE is not included.
- Payload bytes equal to SYNC_BYTE are legal data; there is no resync inside a frame.
- Inter-byte timeout:
  - Counter clears on every byte_valid_in and runs only in states other than SYNC.
  - On reaching TIMEOUT_CYCLES with no byte that cycle: err_count_out += 1 and state -> SYNC.
  - A byte arriving in the expiry cycle is accepted and the timeout does not fire.
- Stale watchdog:
  - Counter clears on each good frame and saturates at STALE_CYCLES.
  - At STALE_CYCLES: link_up_out=0 and controller_out forced to neutral in the same cycle.
  - link_up_out goes to 1 in the same cycle frame_valid_out pulses.
- err_count_out saturates at 8'hFF and never wraps. A checksum error and a timeout cannot coincide.
- frame_valid_out is never high on two consecutive cycles, since a frame needs at least 5 byte strobes.
- byte_valid_in held high continuously is legal: one byte is consumed per cycle.

Optional Feature:
- Macro CTRL_EDGE_EN.
- When defined:
  - Adds output buttons_pressed_out (8 bits).
  - It pulses for one cycle, coincident with frame_valid_out, with (new_buttons & ~prev_buttons).
  - prev_buttons resets to 0 and is forced to 0 when the link goes down, so the first frame after link-up reports every held button.
  - buttons_pressed_out is 0 in all other cycles.
- When undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Good frame: reset, send A5 10 20 03 33 back-to-back -> controller_out=24'h102003 one cycle after the 33 strobe; frame_valid_out single pulse; link_up_out=1; err_count_out=0.
- Bad checksum: send A5 10 20 03 34 -> controller_out stays 24'h808000, no frame_valid_out, err_count_out=1, state SYNC. Then a good frame A5 01 02 04 07 is accepted.
- Garbage and payload equal to SYNC_BYTE: send 00 FF A5 A5 A5 A5 EF -> junk bytes ignored, controller_out=24'hA5A5A5, err_count_out=0.
- Timeout: send A5 10, then idle TIMEOUT_CYCLES -> err_count_out=1, state SYNC. Send a byte exactly at the expiry cycle in a second run -> no error, frame continues.
- Stale: after a good frame, idle STALE_CYCLES (bench overrides to 50) -> link_up_out falls and controller_out=24'h808000 in the same cycle. The next good frame restores link_up_out=1.
- Reset mid-frame plus saturation:
  - Assert rst_in after A5 10 20 -> outputs return to reset values asynchronously.
  - Drive 300 bad frames -> err_count_out holds 8'hFF.
  - With CTRL_EDGE_EN, frames with buttons 01 then 03 -> buttons_pressed_out 01 then 02.
